// File: rtl/sync_pkg.sv
// Shared definitions for the toggle-handshake crossing: synchroniser depth
// limits and the toggle type.
package sync_pkg;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    typedef logic sync_tgl_t;
endpackage

// File: rtl/sync_tgl_chain.sv
// Flop chain that brings an asynchronous toggle into the clk domain.
// q is the last stage; depth outside the legal range fails elaboration.
module sync_tgl_chain
    import sync_pkg::*;
#(
    parameter int syncStages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [syncStages-1:0] ff;

    generate
        if (syncStages < SYNC_STAGES_MIN || syncStages > SYNC_STAGES_MAX) begin : g_bad_depth
            $error("sync_tgl_chain: syncStages must be within 2..4");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[syncStages-2:0], d};
        end
    end

    assign q = ff[syncStages-1];
endmodule

// File: rtl/sync_bus_rx.sv
// Destination side of a toggle-handshake bus crossing: captures the held word
// into a FIFO-style buffer and returns an ack toggle. SYNC_BUS_RX_SKID_EN selects 2 entries.
module sync_bus_rx
    import sync_pkg::*;
#(
    parameter int width      = 32,
    parameter int syncStages = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             sREQ_TGL,
    input  logic [width-1:0] sD_IN,
    output logic             sACK_TGL,
    output logic [width-1:0] D_OUT,
    output logic             EMPTY_N,
    input  logic             DEQ,
    output logic             FULL_N
);
    sync_tgl_t req_s;
    sync_tgl_t req_last;
    logic      new_word;
    logic      pop;
    logic      cap;

    sync_tgl_chain #(
        .syncStages(syncStages)
    ) u_sync (
        .clk  (CLK),
        .rst_n(RST_N),
        .d    (sREQ_TGL),
        .q    (req_s)
    );

    assign new_word = (req_s != req_last);
    assign pop      = DEQ && EMPTY_N;

    // The ack is only returned once the word is safely in the buffer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            req_last <= 1'b0;
            sACK_TGL <= 1'b0;
        end else if (cap) begin
            req_last <= req_s;
            sACK_TGL <= req_s;
        end
    end

`ifdef SYNC_BUS_RX_SKID_EN
    logic [width-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;
    logic [1:0]       cnt_nxt;
    logic [width-1:0] dout_nxt;

    assign cap = new_word && (FULL_N || pop);

    // D_OUT is a dedicated register that tracks the head entry.
    always_comb begin
        cnt_nxt  = cnt + {1'b0, cap} - {1'b0, pop};
        dout_nxt = D_OUT;
        if (pop && cnt == 2'd2) begin
            dout_nxt = mem[~rd_ptr];
        end else if (cap && (cnt == 2'd0 || pop)) begin
            dout_nxt = sD_IN;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            cnt     <= 2'd0;
            D_OUT   <= '0;
            EMPTY_N <= 1'b0;
            FULL_N  <= 1'b1;
        end else begin
            if (cap) wr_ptr <= ~wr_ptr;
            if (pop) rd_ptr <= ~rd_ptr;
            cnt     <= cnt_nxt;
            D_OUT   <= dout_nxt;
            EMPTY_N <= (cnt_nxt != 2'd0);
            FULL_N  <= (cnt_nxt != 2'd2);
        end
    end

    always_ff @(posedge CLK) begin
        if (cap) mem[wr_ptr] <= sD_IN;
    end
`else
    assign cap = new_word && (!EMPTY_N || pop);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            D_OUT   <= '0;
            EMPTY_N <= 1'b0;
            FULL_N  <= 1'b1;
        end else if (cap) begin
            D_OUT   <= sD_IN;
            EMPTY_N <= 1'b1;
            FULL_N  <= 1'b0;
        end else if (pop) begin
            EMPTY_N <= 1'b0;
            FULL_N  <= 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST_N && DEQ && !EMPTY_N) $warning("sync_bus_rx: DEQ while empty ignored");
    end
endmodule
